// File: rtl/autoconfig_master.sv
// Zorro III AutoConfig initiator: probes the 0x00E80000 config window and reads each board's
// nibble ROM, then assigns a base address (Z3) or shuts the board up (anything else).
module autoconfig_master #(
  parameter logic [7:0]  BASE_Z3    = 8'h40,
  parameter logic [7:0]  BASE_STEP  = 8'h08,
  parameter int unsigned MAX_BOARDS = 4,
  parameter int unsigned ACC_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic [31:0] A,
  output logic        AS20,
  output logic        DS20,
  output logic        RW20,
  input  logic [3:0]  DIN,
  output logic [3:0]  DOUT,
  output logic        DOE,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  NBOARDS,
  output logic [7:0]  ER_TYPE,
  output logic [7:0]  PRODUCT,
  output logic [15:0] MFR,
  output logic [7:0]  LAST_BASE
);

  localparam logic [31:0] CfgWindow = 32'h00E80000;
  localparam int unsigned DsCycles  = (ACC_CYCLES > 1) ? ACC_CYCLES - 1 : 1;
  localparam logic [7:0]  DsLast    = 8'(DsCycles - 1);
  localparam logic [3:0]  MaxCount  = 4'(MAX_BOARDS);

  typedef enum logic [2:0] {BIdle, BAddr, BAs, BDs, BLatch, BNeg, BRec} bus_state_e;
  typedef enum logic [2:0] {SIdle, SRd, SDec, SCfg, SShut, SNext, SFin} scan_state_e;

  bus_state_e  bus_q, bus_d;
  scan_state_e scan_q, scan_d;

  logic        req, req_rw, bus_end;
  logic [5:0]  req_zaddr;
  logic [3:0]  req_data;

  logic [31:0] a_q;
  logic        rw_q;
  logic [3:0]  dout_q;
  logic [7:0]  wait_q;
  logic [2:0]  idx_q;
  logic [3:0]  raw_q [8];
  logic [7:0]  base_q;
  logic [2:0]  nboards_q, shut_q;
  logic [7:0]  er_type_q, product_q, last_base_q;
  logic [15:0] mfr_q;

  assign bus_end = (bus_q == BRec);

  // Bus cycle engine
  always_ff @(posedge CLK) begin
    if (RESET) bus_q <= BIdle;
    else       bus_q <= bus_d;
  end

  always_comb begin
    bus_d = bus_q;
    unique case (bus_q)
      BIdle:   if (req) bus_d = BAddr;
      BAddr:   bus_d = BAs;
      BAs:     bus_d = BDs;
      BDs:     if (wait_q == DsLast) bus_d = BLatch;
      BLatch:  bus_d = BNeg;
      BNeg:    bus_d = BRec;
      BRec:    bus_d = BIdle;
      default: bus_d = BIdle;
    endcase
  end

  always_comb begin
    AS20 = !(bus_q inside {BAs, BDs, BLatch});
    DS20 = !(bus_q inside {BDs, BLatch});
    RW20 = (bus_q == BIdle) ? 1'b1 : rw_q;
    DOE  = !rw_q && (bus_q inside {BAddr, BAs, BDs, BLatch, BNeg});
    A    = a_q;
    DOUT = dout_q;
  end

  // Scan sequencer
  always_ff @(posedge CLK) begin
    if (RESET) scan_q <= SIdle;
    else       scan_q <= scan_d;
  end

  always_comb begin
    scan_d = scan_q;
    unique case (scan_q)
      SIdle: if (START) scan_d = SRd;
      SRd: begin
        if (bus_end) begin
          if (idx_q == 3'd0 && raw_q[0] == 4'hf) scan_d = SFin;
          else if (idx_q == 3'd7)                scan_d = SDec;
        end
      end
      SDec:    scan_d = (raw_q[0][3:2] == 2'b10) ? SCfg : SShut;
      SCfg:    if (bus_end) scan_d = SNext;
      SShut:   if (bus_end) scan_d = SNext;
      SNext:   scan_d = (({1'b0, nboards_q} + {1'b0, shut_q}) >= MaxCount) ? SFin : SRd;
      SFin:    scan_d = SIdle;
      default: scan_d = SIdle;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    req_rw    = 1'b1;
    // Read order 0x00..0x03 then 0x08..0x0B
    req_zaddr = {2'b00, idx_q[2], 1'b0, idx_q[1:0]};
    req_data  = 4'h0;
    unique case (scan_q)
      SRd:  req = (bus_q == BIdle);
      SCfg: begin
        req       = (bus_q == BIdle);
        req_rw    = 1'b0;
        req_zaddr = 6'h22;
        req_data  = base_q[7:4];
      end
      SShut: begin
        req       = (bus_q == BIdle);
        req_rw    = 1'b0;
        req_zaddr = 6'h26;
      end
      default: ;
    endcase
    BUSY = !(scan_q inside {SIdle, SFin});
    DONE = (scan_q == SFin);
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_q         <= '0;
      rw_q        <= 1'b1;
      dout_q      <= '0;
      wait_q      <= '0;
      idx_q       <= '0;
      base_q      <= '0;
      nboards_q   <= '0;
      shut_q      <= '0;
      er_type_q   <= '0;
      product_q   <= '0;
      mfr_q       <= '0;
      last_base_q <= '0;
      for (int i = 0; i < 8; i++) raw_q[i] <= '0;
    end else begin
      if (scan_q == SIdle && START) begin
        nboards_q <= '0;
        shut_q    <= '0;
        base_q    <= BASE_Z3;
        idx_q     <= '0;
      end
      if (bus_q == BIdle && req) begin
        a_q    <= CfgWindow | {25'd0, req_zaddr, 1'b0};
        rw_q   <= req_rw;
        dout_q <= req_data;
      end
      if (bus_q == BAs) wait_q <= '0;
      if (bus_q == BDs) wait_q <= wait_q + 8'd1;
      if (bus_q == BLatch && rw_q) raw_q[idx_q] <= DIN;
      if (bus_end) begin
        unique case (scan_q)
          SRd:  idx_q <= idx_q + 3'd1;
          SCfg: begin
            last_base_q <= base_q;
            base_q      <= base_q + BASE_STEP;
            nboards_q   <= nboards_q + 3'd1;
          end
          SShut:   shut_q <= shut_q + 3'd1;
          default: ;
        endcase
      end
      if (scan_q == SNext) idx_q <= '0;
      // er_type nibbles are read true; product and manufacturer nibbles are stored inverted
      if (scan_q == SDec) begin
        er_type_q <= {raw_q[0], raw_q[1]};
        product_q <= ~{raw_q[2], raw_q[3]};
        mfr_q     <= ~{raw_q[4], raw_q[5], raw_q[6], raw_q[7]};
      end
    end
  end

  assign NBOARDS   = nboards_q;
  assign ER_TYPE   = er_type_q;
  assign PRODUCT   = product_q;
  assign MFR       = mfr_q;
  assign LAST_BASE = last_base_q;

endmodule

// File: tb/tb_autoconfig_master.sv
// Bench for autoconfig_master: board-chain bus model plus a scan-level reference model.
module tb_autoconfig_master;
  localparam int unsigned Acc  = 4;
  localparam int unsigned MaxB = 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a;
  logic        as20, ds20, rw20, doe, busy, done;
  logic [3:0]  din, dout;
  logic [2:0]  nboards;
  logic [7:0]  er_type, product, last_base;
  logic [15:0] mfr;

  always #5 clk = ~clk;

  autoconfig_master #(
    .BASE_Z3    (8'h40),
    .BASE_STEP  (8'h08),
    .MAX_BOARDS (MaxB),
    .ACC_CYCLES (Acc)
  ) dut (
    .CLK       (clk),
    .RESET     (reset),
    .START     (start),
    .A         (a),
    .AS20      (as20),
    .DS20      (ds20),
    .RW20      (rw20),
    .DIN       (din),
    .DOUT      (dout),
    .DOE       (doe),
    .BUSY      (busy),
    .DONE      (done),
    .NBOARDS   (nboards),
    .ER_TYPE   (er_type),
    .PRODUCT   (product),
    .MFR       (mfr),
    .LAST_BASE (last_base)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  data;
    int          as_len;
    int          ds_first;
    bit          stable;
    bit          doe_ok;
  } cyc_t;

  // Owned by the monitor
  cyc_t cyc_q[$];
  int   wr_count = 0;

  // Owned by the main sequence
  logic [3:0] roms [8][64];
  int         n_loaded   = 0;
  int         chain_base = 0;
  int         n_checks   = 0;
  int         n_errors   = 0;
  logic [7:0]  m_er, m_prod, m_last;
  logic [15:0] m_mfr;
  int          m_n;

  // The first unconfigured board in the chain answers the window
  int bptr;
  assign bptr = wr_count - chain_base;

  always_comb begin
    din = 4'hf;
    if (!as20 && rw20 && a[31:16] == 16'h00E8 && bptr >= 0 && bptr < n_loaded)
      din = roms[bptr[2:0]][a[6:1]];
  end

  initial begin : monitor
    cyc_t cur;
    bit   in_cyc;
    in_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        in_cyc = 1'b0;
      end else if (as20 === 1'b0) begin
        if (!in_cyc) begin
          in_cyc       = 1'b1;
          cur.addr     = a;
          cur.rw       = rw20;
          cur.data     = dout;
          cur.as_len   = 1;
          cur.ds_first = (ds20 === 1'b0) ? 1 : 0;
          cur.stable   = 1'b1;
          cur.doe_ok   = (doe === !rw20);
        end else begin
          cur.as_len++;
          if (a !== cur.addr || rw20 !== cur.rw || dout !== cur.data) cur.stable = 1'b0;
          if (doe !== !cur.rw) cur.doe_ok = 1'b0;
          if (ds20 === 1'b0 && cur.ds_first == 0) cur.ds_first = cur.as_len;
        end
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        if (a !== cur.addr || dout !== cur.data) cur.stable = 1'b0;
        if (doe !== !cur.rw) cur.doe_ok = 1'b0;
        cyc_q.push_back(cur);
        if (!cur.rw && cur.as_len == int'(Acc) + 1) wr_count++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_boards();
    for (int b = 0; b < 8; b++)
      for (int z = 0; z < 64; z++) roms[b][z] = 4'hf;
    n_loaded   = 0;
    chain_base = wr_count;
  endtask

  // Nibbles for zaddr 00,01,02,03,08,09,0A,0B packed MSB first
  task automatic add_board(input logic [31:0] nibs);
    int zmap [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    for (int k = 0; k < 8; k++) roms[n_loaded][zmap[k]] = nibs[31-4*k -: 4];
    n_loaded++;
  endtask

  task automatic run_scan(input string tag);
    int          zmap [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    logic [31:0] ex_addr[$];
    logic        ex_rw[$];
    logic [3:0]  ex_data[$];
    logic [7:0]  base;
    logic [3:0]  n0;
    int          cnt, first, n_cyc;
    bit          got_done;

    base = 8'h40;
    cnt  = 0;
    m_n  = 0;
    for (int b = 0; b < 8; b++) begin
      n0 = (b < n_loaded) ? roms[b][0] : 4'hf;
      ex_addr.push_back(32'h00E80000); ex_rw.push_back(1'b1); ex_data.push_back(4'h0);
      if (n0 == 4'hf) break;
      for (int k = 1; k < 8; k++) begin
        ex_addr.push_back(32'h00E80000 | (zmap[k] << 1));
        ex_rw.push_back(1'b1);
        ex_data.push_back(4'h0);
      end
      m_er   = {roms[b][0], roms[b][1]};
      m_prod = ~{roms[b][2], roms[b][3]};
      m_mfr  = ~{roms[b][8], roms[b][9], roms[b][10], roms[b][11]};
      if (n0[3:2] == 2'b10) begin
        ex_addr.push_back(32'h00E80044); ex_rw.push_back(1'b0); ex_data.push_back(base[7:4]);
        m_last = base;
        base   = base + 8'h08;
        m_n++;
      end else begin
        ex_addr.push_back(32'h00E8004C); ex_rw.push_back(1'b0); ex_data.push_back(4'h0);
      end
      cnt++;
      if (cnt == int'(MaxB)) break;
    end

    first = cyc_q.size();
    start = 1'b1;
    got_done = 1'b0;
    // A second START while busy must be ignored
    for (int i = 0; i < 2000 && !got_done; i++) begin
      @(negedge clk);
      start = (i == 3);
      if (done === 1'b1) got_done = 1'b1;
    end
    start = 1'b0;
    check_eq({tag, " done seen"}, 32'(got_done), 32'd1);
    check_eq({tag, " busy at done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check_eq({tag, " done one cycle"}, 32'(done), 32'd0);

    n_cyc = cyc_q.size() - first;
    check_eq({tag, " cycle count"}, 32'(n_cyc), 32'(ex_addr.size()));
    for (int i = 0; i < n_cyc && i < ex_addr.size(); i++) begin
      cyc_t c;
      c = cyc_q[first + i];
      check_eq($sformatf("%s c%0d addr", tag, i), c.addr, ex_addr[i]);
      check_eq($sformatf("%s c%0d rw", tag, i), 32'(c.rw), 32'(ex_rw[i]));
      if (!ex_rw[i]) check_eq($sformatf("%s c%0d dout", tag, i), 32'(c.data), 32'(ex_data[i]));
      check_eq($sformatf("%s c%0d as_len", tag, i), 32'(c.as_len), Acc + 1);
      check_eq($sformatf("%s c%0d ds_delay", tag, i), 32'(c.ds_first), 32'd2);
      check_eq($sformatf("%s c%0d stable", tag, i), 32'(c.stable), 32'd1);
      check_eq($sformatf("%s c%0d doe", tag, i), 32'(c.doe_ok), 32'd1);
    end
    check_eq({tag, " nboards"}, 32'(nboards), 32'(m_n));
    check_eq({tag, " er_type"}, 32'(er_type), 32'(m_er));
    check_eq({tag, " product"}, 32'(product), 32'(m_prod));
    check_eq({tag, " mfr"}, 32'(mfr), 32'(m_mfr));
    check_eq({tag, " last_base"}, 32'(last_base), 32'(m_last));
  endtask

  initial begin : main
    bit found;
    reset  = 1'b1;
    start  = 1'b0;
    m_er   = '0; m_prod = '0; m_mfr = '0; m_last = '0;
    clear_boards();
    repeat (3) @(negedge clk);
    check_eq("rst as20", 32'(as20), 32'd1);
    check_eq("rst ds20", 32'(ds20), 32'd1);
    check_eq("rst rw20", 32'(rw20), 32'd1);
    check_eq("rst a", a, 32'd0);
    check_eq("rst dout_doe", {27'd0, dout, doe}, 32'd0);
    check_eq("rst busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst regs", {5'd0, nboards, er_type, product, last_base}, 32'd0);
    check_eq("rst mfr", 32'(mfr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    clear_boards();
    add_board(32'hA3FCEC27);
    run_scan("single");
    check_eq("single er_type const", 32'(er_type), 32'hA3);
    check_eq("single product const", 32'(product), 32'h03);
    check_eq("single mfr const", 32'(mfr), 32'h13D8);
    check_eq("single last_base const", 32'(last_base), 32'h40);

    clear_boards();
    run_scan("empty");

    clear_boards();
    add_board(32'hA3FCEC27);
    add_board(32'h8112_3456);
    run_scan("two_z3");
    check_eq("two_z3 last_base const", 32'(last_base), 32'h48);

    clear_boards();
    add_board(32'hC3FCEC27);
    run_scan("z2");

    // Reset in the middle of the base-address write
    clear_boards();
    add_board(32'hA3FCEC27);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (a === 32'h00E80044 && ds20 === 1'b0) found = 1'b1;
    end
    check_eq("midrst reached write", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst strobes", {30'd0, as20, ds20}, 32'd3);
    check_eq("midrst doe", 32'(doe), 32'd0);
    check_eq("midrst busy", 32'(busy), 32'd0);
    check_eq("midrst unconfigured", 32'(wr_count - chain_base), 32'd0);
    reset = 1'b0;
    m_er = '0; m_prod = '0; m_mfr = '0; m_last = '0;
    @(negedge clk);
    run_scan("after_rst");

    for (int s = 0; s < 20; s++) begin
      int nb;
      clear_boards();
      nb = $urandom_range(0, 5);
      for (int b = 0; b < nb; b++) begin
        logic [3:0]  n0;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
          0:       n0 = {2'b10, 2'($urandom_range(0, 3))};
          1:       n0 = {2'b11, 2'($urandom_range(0, 2))};
          default: n0 = {1'b0, 3'($urandom_range(0, 7))};
        endcase
        add_board({n0, r[27:0]});
      end
      run_scan($sformatf("rnd%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
